// File: rtl/mips_data_mem_pkg.sv
// Shared constants and the address-decode enum for the data-side memory responder.
package mips_data_mem_pkg;

  localparam logic [31:0] OFF_CON_DATA = 32'h0000_0000;
  localparam logic [31:0] OFF_CON_STAT = 32'h0000_0004;
  localparam logic [31:0] OFF_CYCLE    = 32'h0000_0008;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    DEC_RAM,
    DEC_CON_DATA,
    DEC_CON_STAT,
    DEC_CYCLE,
    DEC_NONE
  } dec_t;

endpackage

// File: rtl/mips_data_mem_if.sv
// CPU data port: the CPU is the master, the memory responder is the slave.
interface mips_data_mem_if;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport master (
    output data_address, data_write, data_read, data_writedata,
    input  data_readdata
  );

  modport slave (
    input  data_address, data_write, data_read, data_writedata,
    output data_readdata
  );
endinterface

// File: rtl/mips_data_mem_console_fifo.sv
// Show-ahead FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module mips_console_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/mips_data_mem.sv
// Data-side memory responder: word RAM, cycle counter, console MMIO and a sticky fault flag.
// Define MIPS_DATA_MEM_CONSOLE_EN to include the console FIFO with CONSOLE_DATA/CONSOLE_STATUS.
module mips_data_mem
  import mips_data_mem_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = 32'h1000_0000,
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clk_enable,
  mips_data_mem_if.slave bus,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  input  logic           tx_ready,
  output logic           err
);
  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   ram_off;
  logic [AW-1:0] ram_idx;
  dec_t          dec;
  logic          fault;
  logic          wr_en;
  logic [31:0]   cycle_reg;
  logic          err_reg;

  // Offset subtraction wraps addresses below RAM_BASE to large values, so one compare covers both ends.
  assign ram_off = bus.data_address - RAM_BASE;
  assign ram_idx = ram_off[AW+1:2];

  always_comb begin
    dec = DEC_NONE;
    if (bus.data_address[1:0] == 2'b00) begin
      if (ram_off < RAM_BYTES) begin
        dec = DEC_RAM;
      end else if (bus.data_address == MMIO_BASE + OFF_CYCLE) begin
        dec = DEC_CYCLE;
`ifdef MIPS_DATA_MEM_CONSOLE_EN
      end else if (bus.data_address == MMIO_BASE + OFF_CON_DATA) begin
        dec = DEC_CON_DATA;
      end else if (bus.data_address == MMIO_BASE + OFF_CON_STAT) begin
        dec = DEC_CON_STAT;
`endif
      end
    end
  end

  assign fault = ((bus.data_read || bus.data_write) && (dec == DEC_NONE)) ||
                 (bus.data_read && bus.data_write);
  assign wr_en = clk_enable && bus.data_write && (dec != DEC_NONE);
  assign err   = err_reg;

  always_ff @(posedge clk) begin
    if (wr_en && (dec == DEC_RAM)) begin
      ram[ram_idx] <= bus.data_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else if (clk_enable) begin
      if (wr_en && (dec == DEC_CYCLE)) begin
        cycle_reg <= bus.data_writedata;
      end else begin
        cycle_reg <= cycle_reg + 32'h1;
      end
      if (fault) begin
        err_reg <= 1'b1;
      end
    end
  end

`ifdef MIPS_DATA_MEM_CONSOLE_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          ovf_reg;
  logic [CW-1:0] count;
  logic [31:0]   status;

  assign push     = wr_en && (dec == DEC_CON_DATA);
  assign tx_valid = !empty;
  assign pop      = tx_valid && tx_ready;

  mips_console_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (bus.data_writedata[7:0]),
    .pop       (pop),
    .head      (tx_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_reg <= 1'b0;
    end else if (push && full && !pop) begin
      ovf_reg <= 1'b1;
    end
  end

  always_comb begin
    status                          = 32'h0;
    status[STAT_FULL]               = full;
    status[STAT_EMPTY]              = empty;
    status[STAT_OVERFLOW]           = ovf_reg;
    status[STAT_COUNT_LSB +: 8]     = 8'(count);
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic unused_tx_ready;

  assign unused_tx_ready = tx_ready;
  assign tx_valid        = 1'b0;
  assign tx_data         = 8'h0;
`endif

  always_comb begin
    bus.data_readdata = 32'h0;
    if (bus.data_read) begin
      case (dec)
        DEC_RAM:      bus.data_readdata = ram[ram_idx];
        DEC_CYCLE:    bus.data_readdata = cycle_reg;
`ifdef MIPS_DATA_MEM_CONSOLE_EN
        DEC_CON_STAT: bus.data_readdata = status;
`endif
        default:      bus.data_readdata = 32'h0;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_data_mem.sv
// Bench for mips_data_mem: vector table, hand-written corner sequences, then randomized traffic vs. a model.
module tb_mips_data_mem;
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam int          RAM_WORDS = 1024;
  localparam logic [31:0] MMIO      = 32'hFFFF_0000;
  localparam int          DEPTH     = 8;
`ifdef MIPS_DATA_MEM_CONSOLE_EN
  localparam bit CON_EN = 1'b1;
`else
  localparam bit CON_EN = 1'b0;
`endif
  localparam int K_NONE = 0, K_RAM = 1, K_CYC = 2, K_CD = 3, K_CS = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk_enable = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       err;

  mips_data_mem_if bus ();

  mips_data_mem #(
    .RAM_BASE   (RAM_BASE),
    .RAM_WORDS  (RAM_WORDS),
    .MMIO_BASE  (MMIO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_enable (clk_enable),
    .bus        (bus),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [31:0] mram [int];
  logic [7:0]  q [$];
  logic [31:0] m_cnt;
  logic        m_err;
  logic        m_ovf;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [31:0] a, input logic r, input logic w,
                     input logic [31:0] d, input logic ce);
    bus.data_address   = a;
    bus.data_read      = r;
    bus.data_write     = w;
    bus.data_writedata = d;
    clk_enable         = ce;
  endtask

  task automatic idle();
    drv(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic tick();
    $display("txn t=%0t addr=%h rd=%0b wr=%0b wd=%h ce=%0b rdy=%0b rdata=%h txv=%0b txd=%h err=%0b",
             $time, bus.data_address, bus.data_read, bus.data_write, bus.data_writedata,
             clk_enable, tx_ready, bus.data_readdata, tx_valid, tx_data, err);
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    q.delete();
    m_cnt = 32'h0;
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    m_reset();
  endtask

  function automatic int m_kind(input logic [31:0] a);
    longint la;
    la = longint'({32'h0, a});
    if (a[1:0] != 2'b00) return K_NONE;
    if (la >= longint'({32'h0, RAM_BASE}) && la < longint'({32'h0, RAM_BASE}) + 4 * RAM_WORDS)
      return K_RAM;
    if (a == MMIO + 32'd8) return K_CYC;
    if (CON_EN && a == MMIO) return K_CD;
    if (CON_EN && a == MMIO + 32'd4) return K_CS;
    return K_NONE;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - RAM_BASE) >> 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic rd);
    int k;
    if (!rd) return 32'h0;
    k = m_kind(a);
    if (k == K_RAM) return mram.exists(m_idx(a)) ? mram[m_idx(a)] : 32'h0;
    if (k == K_CYC) return m_cnt;
    if (k == K_CS)
      return (32'(q.size()) << 8) | (32'(m_ovf) << 2) |
             (32'(q.size() == 0) << 1) | 32'(q.size() == DEPTH);
    return 32'h0;
  endfunction

  task automatic m_edge(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic ce, input logic rdy);
    int k;
    bit popped, was_full;
    k        = m_kind(a);
    popped   = rdy && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    if (popped) void'(q.pop_front());
    if (ce) begin
      if (((rd || wr) && k == K_NONE) || (rd && wr)) m_err = 1'b1;
      if (wr && k == K_RAM) mram[m_idx(a)] = wd;
      if (wr && k == K_CYC) m_cnt = wd;
      else m_cnt = m_cnt + 32'h1;
      if (wr && k == K_CD) begin
        if (!was_full || popped) q.push_back(wd[7:0]);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic rstep(input logic [31:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic ce, input logic rdy);
    drv(a, rd, wr, wd, ce);
    tx_ready = rdy;
    #1;
    chk("rnd_rdata", bus.data_readdata, m_read(a, rd));
    chk("rnd_txv", 32'(tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("rnd_txd", 32'(tx_data), 32'(q[0]));
    chk("rnd_err", 32'(err), 32'(m_err));
    m_edge(a, rd, wr, wd, ce, rdy);
    tick();
  endtask

  task automatic add_vec(input string n, input logic [31:0] a, input logic r, input logic w,
                         input logic [31:0] d, input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = n; v.addr = a; v.rd = r; v.wr = w; v.wd = d; v.exp_rd = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    drv(MMIO + 32'd8, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_txv", 32'(tx_valid), 32'h0);
    chk("rst_cycle", bus.data_readdata, 32'h0);
    reset_n = 1'b1;
    idle();
    tick();

    // Write then read back next cycle.
    do_reset();
    drv(RAM_BASE + 32'd8, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
    tick();
    drv(RAM_BASE + 32'd8, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("wr_rd_data", bus.data_readdata, 32'hCAFE_F00D);
    tick();
    chk("wr_rd_err", 32'(err), 32'h0);
    drv(RAM_BASE + 32'd4092, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
    tick();

    add_vec("ram_rd",     RAM_BASE + 32'd8,    1, 0, 32'h0, 32'hCAFE_F00D, 0);
    add_vec("ram_last",   RAM_BASE + 32'd4092, 1, 0, 32'h0, 32'hA5A5_0001, 0);
    add_vec("misalign",   RAM_BASE + 32'd2,    1, 0, 32'h0, 32'h0, 1);
    add_vec("past_end",   RAM_BASE + 32'd4096, 1, 0, 32'h0, 32'h0, 1);
    add_vec("below_base", RAM_BASE - 32'd4,    1, 0, 32'h0, 32'h0, 1);
    add_vec("cyc_rst",    MMIO + 32'd8,        1, 0, 32'h0, 32'h0, 0);
    add_vec("mmio_hole",  MMIO + 32'd12,       1, 0, 32'h0, 32'h0, 1);
    add_vec("con_data",   MMIO,                1, 0, 32'h0, 32'h0, !CON_EN);
    add_vec("con_stat",   MMIO + 32'd4,        1, 0, 32'h0, CON_EN ? 32'h2 : 32'h0, !CON_EN);
    add_vec("no_strobe",  RAM_BASE + 32'd3,    0, 0, 32'h0, 32'h0, 0);
    add_vec("rd_low",     RAM_BASE + 32'd8,    0, 0, 32'h0, 32'h0, 0);
    add_vec("mis_wr",     RAM_BASE + 32'd10,   0, 1, 32'hDEAD_BEEF, 32'h0, 1);
    add_vec("after_mis",  RAM_BASE + 32'd8,    1, 0, 32'h0, 32'hCAFE_F00D, 0);
    add_vec("both",       RAM_BASE + 32'd8,    1, 1, 32'h1111_1111, 32'hCAFE_F00D, 1);
    add_vec("after_both", RAM_BASE + 32'd8,    1, 0, 32'h0, 32'h1111_1111, 0);
    add_vec("unmap_wr",   32'h0000_0100,       0, 1, 32'h5555_5555, 32'h0, 1);
    add_vec("stat_wr",    MMIO + 32'd4,        0, 1, 32'h0000_00FF, 32'h0, !CON_EN);
    for (int i = 0; i < vecs.size(); i++) begin
      do_reset();
      drv(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wd, 1'b1);
      #1;
      chk({vecs[i].name, "_rdata"}, bus.data_readdata, vecs[i].exp_rd);
      tick();
      chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      idle();
    end

    // Stalled writes and reads: nothing changes while clk_enable is low.
    do_reset();
    drv(RAM_BASE + 32'd4, 1'b0, 1'b1, 32'h0BAD_0004, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(RAM_BASE + 32'd4, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
      tick();
    end
    drv(RAM_BASE + 32'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("stall_ram", bus.data_readdata, 32'h0BAD_0004);
    tick();
    drv(MMIO + 32'd8, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("stall_cycle", bus.data_readdata, 32'h1);
    tick();
    drv(RAM_BASE + 32'd2, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("stall_fault_err", 32'(err), 32'h0);

    // Counter load and wrap.
    do_reset();
    drv(MMIO + 32'd8, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    tick();
    drv(MMIO + 32'd8, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("cyc_load", bus.data_readdata, 32'hFFFF_FFFE);
    tick();
    chk("cyc_max", bus.data_readdata, 32'hFFFF_FFFF);
    tick();
    chk("cyc_wrap", bus.data_readdata, 32'h0000_0000);
    idle();

`ifdef MIPS_DATA_MEM_CONSOLE_EN
    // Fill, overflow, drain.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv(MMIO, 1'b0, 1'b1, 32'(8'h41 + i), 1'b1);
      #1;
      if (i == 0) chk("txv_pre_push", 32'(tx_valid), 32'h0);
      tick();
      if (i == 0) chk("txv_post_push", 32'(tx_valid), 32'h1);
    end
    drv(MMIO, 1'b0, 1'b1, 32'h49, 1'b1);
    tick();
    drv(MMIO + 32'd4, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("stat_full_ovf", bus.data_readdata, 32'h0000_0805);
    tick();
    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(tx_valid), 32'h1);
      chk("drain_data", 32'(tx_data), 32'(8'h41 + i));
      tick();
    end
    chk("drain_empty", 32'(tx_valid), 32'h0);
    chk("console_err", 32'(err), 32'h0);

    // Push into a full FIFO while it pops.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv(MMIO, 1'b0, 1'b1, 32'(8'h41 + i), 1'b1);
      tick();
    end
    drv(MMIO, 1'b0, 1'b1, 32'h5A, 1'b1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    drv(MMIO + 32'd4, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("full_pushpop_stat", bus.data_readdata, 32'h0000_0805);
    chk("full_pushpop_head", 32'(tx_data), 32'h42);
    tick();
    drv(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("stall_drain", 32'(tx_data), (i == 7) ? 32'h5A : 32'(8'h42 + i));
      tick();
    end
    chk("stall_drain_empty", 32'(tx_valid), 32'h0);

    // Push and pop on an empty FIFO: no bypass.
    drv(MMIO, 1'b0, 1'b1, 32'h77, 1'b1);
    tick();
    idle();
    chk("empty_pushpop_v", 32'(tx_valid), 32'h1);
    chk("empty_pushpop_d", 32'(tx_data), 32'h77);
    tick();
    chk("empty_pushpop_gone", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    drv(MMIO, 1'b0, 1'b1, 32'h33, 1'b1);
    tick();
`else
    do_reset();
    drv(MMIO, 1'b0, 1'b1, 32'h41, 1'b1);
    tick();
    chk("nocon_txv", 32'(tx_valid), 32'h0);
    chk("nocon_txd", 32'(tx_data), 32'h0);
`endif

    // Asynchronous reset mid-operation.
    drv(RAM_BASE + 32'd1, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    idle();
    chk("pre_areset_err", 32'(err), 32'h1);
    chk("pre_areset_txv", 32'(tx_valid), 32'(CON_EN));
    reset_n = 1'b0;
    #1;
    chk("areset_err", 32'(err), 32'h0);
    chk("areset_txv", 32'(tx_valid), 32'h0);
    reset_n = 1'b1;
    m_reset();
    tick();

    // Randomized traffic against the model.
    for (int b = 0; b < 4; b++) begin
      do_reset();
      if (b == 0) begin
        for (int w = 0; w < 16; w++)
          rstep(RAM_BASE + 32'(4 * w), 1'b0, 1'b1, $urandom, 1'b1, 1'b0);
      end
      for (int n = 0; n < 60; n++) begin
        int sel, rw;
        logic [31:0] a;
        logic r, w;
        sel = $urandom_range(0, 31);
        if (sel < 16)      a = RAM_BASE + 32'(4 * $urandom_range(0, 15));
        else if (sel < 20) a = MMIO + 32'd8;
        else if (sel < 26) a = MMIO;
        else if (sel < 29) a = MMIO + 32'd4;
        else if (sel == 30) a = $urandom & 32'h0FFF_FFFC;
        else               a = RAM_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        rw = $urandom_range(0, 15);
        r  = (rw <= 7);
        w  = (rw == 0) || (rw >= 8 && rw <= 13);
        rstep(a, r, w, $urandom, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
